// File: rtl/ctrl_uart_tx_pkg.sv
// Shared types and ASCII constants for the control-event UART reporter.
// encode() maps a control event onto its key character, optionally uppercase.
package ctrl_uart_tx_pkg;

  typedef enum logic [2:0] {
    NOEVENT,
    LEFT,
    RIGHT,
    DOWN,
    DROP,
    HOLD,
    ROTATE,
    ROTATE_REV
  } control_type;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  typedef enum logic [1:0] {
    CHAR,
    CR,
    LF
  } phase_e;

  localparam logic [7:0] ASCII_LEFT       = 8'h61;
  localparam logic [7:0] ASCII_RIGHT      = 8'h64;
  localparam logic [7:0] ASCII_DOWN       = 8'h77;
  localparam logic [7:0] ASCII_DROP       = 8'h73;
  localparam logic [7:0] ASCII_HOLD       = 8'h63;
  localparam logic [7:0] ASCII_ROTATE     = 8'h78;
  localparam logic [7:0] ASCII_ROTATE_REV = 8'h7A;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_CASE_BIT   = 8'h20;

  function automatic logic [7:0] encode(control_type ev, logic upper);
    logic [7:0] code;
    case (ev)
      LEFT:       code = ASCII_LEFT;
      RIGHT:      code = ASCII_RIGHT;
      DOWN:       code = ASCII_DOWN;
      DROP:       code = ASCII_DROP;
      HOLD:       code = ASCII_HOLD;
      ROTATE:     code = ASCII_ROTATE;
      ROTATE_REV: code = ASCII_ROTATE_REV;
      default:    code = 8'h00;
    endcase
    if (upper) code = code & ~ASCII_CASE_BIT;
    return code;
  endfunction

endpackage

// File: rtl/ctrl_uart_tx_event_fifo.sv
// Generic FIFO of DEPTH (power of two) entries of type T; head is shown combinationally.
// Push while full and pop while empty are ignored; full is judged before a same-cycle pop.
module event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ctrl_uart_tx.sv
// Queues control events and reports each as one ASCII byte through a uart core handshake.
// Define CTRL_UART_TX_NEWLINE_EN to follow every character with CR then LF.
module ctrl_uart_tx
  import ctrl_uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned UPPER = 0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  control_type event_i,
  input  logic        event_valid_i,
  input  logic        is_transmitting_i,
  output logic        transmit_o,
  output logic [7:0]  tx_byte_o,
  output logic        full_o,
  output logic        busy_o,
  output logic        overflow_o
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        overflow_q, overflow_d;
  logic        offered;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  control_type head;

  assign offered    = event_valid_i && (event_i != NOEVENT);
  assign push       = offered && !full_o;
  assign overflow_d = overflow_q || (offered && full_o);

  event_fifo #(
    .DEPTH (DEPTH),
    .T     (control_type)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_n_i),
    .push_i  (push),
    .data_i  (event_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full_o),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef CTRL_UART_TX_NEWLINE_EN
        // A pending CR/LF takes priority over the queue so the line completes first.
        if (phase_q == CR) begin
          tx_byte_d = ASCII_CR;
          state_d   = SEND;
        end else if (phase_q == LF) begin
          tx_byte_d = ASCII_LF;
          state_d   = SEND;
        end else
`endif
        if (!fifo_empty && (phase_q == CHAR)) begin
          pop       = 1'b1;
          tx_byte_d = encode(head, UPPER != 0);
          phase_d   = CHAR;
          state_d   = SEND;
        end
      end
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (is_transmitting_i) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!is_transmitting_i) begin
          state_d = IDLE;
`ifdef CTRL_UART_TX_NEWLINE_EN
          case (phase_q)
            CHAR:    phase_d = CR;
            CR:      phase_d = LF;
            default: phase_d = CHAR;
          endcase
`endif
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      phase_q    <= CHAR;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  assign transmit_o = (state_q == SEND);
  assign tx_byte_o  = tx_byte_q;
  assign overflow_o = overflow_q;
`ifdef CTRL_UART_TX_NEWLINE_EN
  assign busy_o = (state_q != IDLE) || !fifo_empty || (phase_q != CHAR);
`else
  assign busy_o = (state_q != IDLE) || !fifo_empty;
`endif

endmodule

// File: tb/tb_ctrl_uart_tx.sv
// Bench for ctrl_uart_tx: lowercase and uppercase instances share stimulus and a uart busy model;
// expected bytes come from a queue of accepted events encoded from the key table.
`timescale 1ns/1ps
module tb_ctrl_uart_tx;
  import ctrl_uart_tx_pkg::*;

  localparam int DEPTH = 8;
`ifdef CTRL_UART_TX_NEWLINE_EN
  localparam int NB = 3;
`else
  localparam int NB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  control_type ev;
  logic        ev_vld;
  logic        is_tx;
  logic        model_busy;
  logic        hold_busy;
  logic        tx_lo, tx_up;
  logic [7:0]  byte_lo, byte_up;
  logic        full_lo, full_up, busy_lo, busy_up, ovf_lo, ovf_up;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];
  int          last_fall = -1;
  int          exp_strobe_cyc = -1;
  int          strobes = 0;
  logic        prev_is_tx = 1'b0;
  logic        prev_tx = 1'b0;
  logic [7:0]  inflight = 8'h00;
  logic        inflight_vld = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign is_tx = model_busy | hold_busy;

  ctrl_uart_tx #(.DEPTH(DEPTH), .UPPER(0)) u_lo (
    .clk_i(clk), .reset_n_i(rst_n), .event_i(ev), .event_valid_i(ev_vld),
    .is_transmitting_i(is_tx), .transmit_o(tx_lo), .tx_byte_o(byte_lo),
    .full_o(full_lo), .busy_o(busy_lo), .overflow_o(ovf_lo));

  ctrl_uart_tx #(.DEPTH(DEPTH), .UPPER(1)) u_up (
    .clk_i(clk), .reset_n_i(rst_n), .event_i(ev), .event_valid_i(ev_vld),
    .is_transmitting_i(is_tx), .transmit_o(tx_up), .tx_byte_o(byte_up),
    .full_o(full_up), .busy_o(busy_up), .overflow_o(ovf_up));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] key_char(control_type e);
    case (e)
      LEFT:       return "a";
      RIGHT:      return "d";
      DOWN:       return "w";
      DROP:       return "s";
      HOLD:       return "c";
      ROTATE:     return "x";
      ROTATE_REV: return "z";
      default:    return 8'h00;
    endcase
  endfunction

  task automatic expect_event(input control_type e);
    exp_q.push_back(key_char(e));
`ifdef CTRL_UART_TX_NEWLINE_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic drive(input logic v, input control_type e);
    @(negedge clk);
    ev_vld = v;
    ev     = e;
  endtask

  task automatic wait_drain(input string tag, input logic exp_ovf);
    int n = 0;
    while ((exp_q.size() != 0 || busy_lo || is_tx) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, int'(n < 3000), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_lo"}, busy_lo, 0);
    chk({tag, "_busy_up"}, busy_up, 0);
    chk({tag, "_full"}, full_up, 0);
    chk({tag, "_ovf_lo"}, ovf_lo, exp_ovf);
    chk({tag, "_ovf_up"}, ovf_up, exp_ovf);
  endtask

  // Uart core model: goes busy 1-3 cycles after a strobe, for 2-5 cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_lo && rst_n) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat ($urandom_range(2, 5)) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_fall    = -1;
      inflight_vld = 1'b0;
    end else begin
      if (tx_lo) begin
        chk("strobe_up_aligned", tx_up, 1);
        chk("strobe_one_cycle", prev_tx, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", tx_lo, 0);
        end else begin
          inflight     = exp_q.pop_front();
          inflight_vld = 1'b1;
          chk("byte_lo", byte_lo, inflight);
          chk("byte_up", byte_up, inflight & 8'hDF);
          if (!hold_busy) chk("strobe_after_fall", is_tx, 0);
          if (last_fall >= 0) chk("strobe_gap", int'(cyc - last_fall >= 2), 1);
          if (exp_strobe_cyc >= 0) begin
            chk("latency", cyc, exp_strobe_cyc);
            exp_strobe_cyc = -1;
          end
        end
        strobes++;
      end
      if (prev_is_tx && !is_tx) begin
        last_fall = cyc;
        if (inflight_vld) chk("byte_stable", byte_lo, inflight);
        inflight_vld = 1'b0;
      end
    end
    prev_is_tx = is_tx;
    prev_tx    = tx_lo;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0, acc, occ, n;
    logic        ovf_m, v;
    control_type e;
    control_type burst [8];
    burst = '{ROTATE, ROTATE_REV, HOLD, DROP, DOWN, RIGHT, LEFT, ROTATE};
    rst_n = 1'b0; ev = NOEVENT; ev_vld = 1'b0; hold_busy = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_transmit", tx_lo, 0);
    chk("rst_tx_byte", byte_lo, 0);
    chk("rst_full", full_lo, 0);
    chk("rst_busy", busy_lo, 0);
    chk("rst_overflow", ovf_up, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single LEFT event pushed in cycle 10.
    while (cyc < 10) @(negedge clk);
    s0 = strobes;
    ev = LEFT; ev_vld = 1'b1;
    expect_event(LEFT);
    exp_strobe_cyc = cyc + 2;
    drive(1'b0, NOEVENT);
    wait_drain("single", 1'b0);
    chk("single_strobes", strobes - s0, NB);

    // Burst of eight consecutive events.
    s0 = strobes;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, burst[i]);
      expect_event(burst[i]);
    end
    drive(1'b0, NOEVENT);
    wait_drain("burst", 1'b0);
    chk("burst_strobes", strobes - s0, 8 * NB);

    // NOEVENT is never queued; DROP gives 's' / 'S'.
    s0 = strobes;
    drive(1'b1, NOEVENT);
    drive(1'b1, DROP);
    chk("noevent_ignored", busy_lo, 0);
    expect_event(DROP);
    drive(1'b0, NOEVENT);
    chk("drop_queued", busy_lo, 1);
    wait_drain("noevent", 1'b0);
    chk("noevent_strobes", strobes - s0, NB);

    // Overflow: FSM parked in WAIT_DONE by a held busy, then nine pushes.
    s0 = strobes;
    hold_busy = 1'b1;
    drive(1'b1, HOLD);
    expect_event(HOLD);
    drive(1'b0, NOEVENT);
    repeat (6) @(negedge clk);
    occ = 0; ovf_m = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = control_type'($urandom_range(1, 7));
      drive(1'b1, e);
      if (i > 0) begin
        chk("ovf_full", full_lo, int'(occ == DEPTH));
        chk("ovf_flag", ovf_lo, ovf_m);
      end
      if (occ < DEPTH) begin
        occ++;
        expect_event(e);
      end else begin
        ovf_m = 1'b1;
      end
    end
    drive(1'b0, NOEVENT);
    chk("ovf_full_end", full_lo, 1);
    chk("ovf_flag_end", ovf_lo, ovf_m);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", ovf_up, 1);
    hold_busy = 1'b0;
    wait_drain("ovf", 1'b1);
    chk("ovf_strobes", strobes - s0, (1 + DEPTH) * NB);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("ovf_cleared_by_reset", ovf_lo, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset while a byte is in flight and three events are queued.
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = control_type'($urandom_range(1, 7));
      drive(1'b1, e);
      expect_event(e);
    end
    drive(1'b0, NOEVENT);
    repeat (6) @(negedge clk);
    chk("midbyte_busy", busy_lo, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midbyte_rst_transmit", tx_lo, 0);
    chk("midbyte_rst_busy", busy_lo, 0);
    chk("midbyte_rst_full", full_lo, 0);
    chk("midbyte_rst_byte", byte_up, 0);
    exp_q.delete();
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    s0 = strobes;
    repeat (20) @(negedge clk);
    chk("no_strobe_after_reset", strobes - s0, 0);
    drive(1'b1, RIGHT);
    expect_event(RIGHT);
    exp_strobe_cyc = cyc + 2;
    drive(1'b0, NOEVENT);
    wait_drain("after_reset", 1'b0);
    chk("after_reset_strobes", strobes - s0, NB);

    // Randomized rounds with gaps and NOEVENT mixed in.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, DEPTH);
      s0 = strobes; acc = 0;
      for (int i = 0; i < n; i++) begin
        e = control_type'($urandom_range(0, 7));
        v = ($urandom_range(0, 3) != 0);
        drive(v, e);
        if (v && e != NOEVENT) begin
          expect_event(e);
          acc++;
        end
      end
      drive(1'b0, NOEVENT);
      wait_drain("rand", 1'b0);
      chk("rand_strobes", strobes - s0, acc * NB);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
